// File: rtl/afifo_rd_ctrl.sv
// Read-domain pointer and status controller for an asynchronous FIFO.
// Owns the binary and Gray read pointers, synchronises the write-domain Gray
// pointer into rclk, and registers empty, almost-empty, occupancy and underflow.
// Optional feature macro: AFIFO_RD_LEVEL_EN builds the occupancy path
// (Gray-to-binary converter and subtractor). Without it, rlevel is tied to 0
// and raempty follows rempty cycle for cycle.
module afifo_rd_ctrl #(
    parameter int unsigned ADDR_SIZE   = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rpop,
    input  logic [ADDR_SIZE:0]   wptr_gray,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic [ADDR_SIZE:0]   rlevel,
    output logic                 rpop_err
);

    localparam int unsigned PTR_W = ADDR_SIZE + 1;

    // Elaboration-time parameter range checks.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("afifo_rd_ctrl: SYNC_STAGES must be at least 2");
    end
    if (AE_THRESH > (1 << ADDR_SIZE)) begin : g_bad_thresh
        $error("afifo_rd_ctrl: AE_THRESH exceeds FIFO depth");
    end

    logic [PTR_W-1:0] rbin_q,  rbin_d;
    logic [PTR_W-1:0] rptr_q,  rptr_d;
    logic             rempty_q,   rempty_d;
    logic             raempty_q,  raempty_d;
    logic             rpop_err_q, rpop_err_d;
    logic             pop_ok_c;

    logic [PTR_W-1:0] sync_q [SYNC_STAGES];
    logic [PTR_W-1:0] sync_d [SYNC_STAGES];
    logic [PTR_W-1:0] wq_gray;

    assign wq_gray = sync_q[SYNC_STAGES-1];

    // Write-pointer synchroniser shift chain.
    always_comb begin
        sync_d[0] = wptr_gray;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

`ifdef AFIFO_RD_LEVEL_EN
    localparam logic [PTR_W-1:0] AE_THRESH_W = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] rlevel_q, rlevel_d;
    logic [PTR_W-1:0] wq_bin;
    logic [PTR_W-1:0] level_c;

    // Gray-to-binary conversion of the synchronised write pointer (XOR prefix from MSB).
    always_comb begin
        wq_bin[PTR_W-1] = wq_gray[PTR_W-1];
        for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
            wq_bin[i] = wq_bin[i+1] ^ wq_gray[i];
        end
    end
`endif

    // Next-state: pointer advance, empty look-ahead, occupancy and underflow.
    always_comb begin
        pop_ok_c   = rpop & ~rempty_q;
        rbin_d     = rbin_q + PTR_W'(pop_ok_c);
        rptr_d     = (rbin_d >> 1) ^ rbin_d;
        rempty_d   = (rptr_d == wq_gray);
        rpop_err_d = rpop & rempty_q;
`ifdef AFIFO_RD_LEVEL_EN
        level_c    = wq_bin - rbin_d;
        rlevel_d   = level_c;
        raempty_d  = (level_c <= AE_THRESH_W);
`else
        raempty_d  = rempty_d;
`endif
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            rbin_q     <= '0;
            rptr_q     <= '0;
            rempty_q   <= 1'b1;
            raempty_q  <= 1'b1;
            rpop_err_q <= 1'b0;
`ifdef AFIFO_RD_LEVEL_EN
            rlevel_q   <= '0;
`endif
        end else begin
            sync_q     <= sync_d;
            rbin_q     <= rbin_d;
            rptr_q     <= rptr_d;
            rempty_q   <= rempty_d;
            raempty_q  <= raempty_d;
            rpop_err_q <= rpop_err_d;
`ifdef AFIFO_RD_LEVEL_EN
            rlevel_q   <= rlevel_d;
`endif
        end
    end

    assign raddr    = rbin_q[ADDR_SIZE-1:0];
    assign rptr     = rptr_q;
    assign rempty   = rempty_q;
    assign raempty  = raempty_q;
    assign rpop_err = rpop_err_q;
`ifdef AFIFO_RD_LEVEL_EN
    assign rlevel   = rlevel_q;
`else
    assign rlevel   = '0;
`endif

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Bench for afifo_rd_ctrl (ADDR_SIZE=3, SYNC_STAGES=2, AE_THRESH=1).
// Directed vector table, a wrap-around stream, and randomized traffic against
// a count-based reference model (total writes/reads with a two-edge visibility lag).
module tb_afifo_rd_ctrl;

`ifdef AFIFO_RD_LEVEL_EN
    localparam bit LEVEL_EN = 1'b1;
`else
    localparam bit LEVEL_EN = 1'b0;
`endif

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       rpop = 1'b0;
    logic [3:0] wptr_gray = 4'd0;
    logic       rempty, raempty, rpop_err;
    logic [2:0] raddr;
    logic [3:0] rptr, rlevel;

    afifo_rd_ctrl #(.ADDR_SIZE(3), .SYNC_STAGES(2), .AE_THRESH(1)) dut (
        .rclk(rclk), .rrst(rrst), .rpop(rpop), .wptr_gray(wptr_gray),
        .rempty(rempty), .raempty(raempty), .raddr(raddr), .rptr(rptr),
        .rlevel(rlevel), .rpop_err(rpop_err)
    );

    always #5 rclk = ~rclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: totals since reset.
    int wtot    = 0;
    int m_reads = 0;
    int m_level = 0;
    bit m_empty = 1'b1;
    bit m_err   = 1'b0;
    int hist[$];

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one rclk edge using the inputs presented at that edge.
    task automatic model_edge(input logic rst, input logic pop);
        int vis;
        if (rst) begin
            m_reads = 0;
            m_empty = 1'b1;
            m_level = 0;
            m_err   = 1'b0;
            hist.delete();
            hist.push_back(0);
            hist.push_back(0);
        end else begin
            vis = hist.pop_front();
            hist.push_back(wtot);
            m_err = pop && m_empty;
            if (pop && !m_empty) m_reads++;
            m_level = vis - m_reads;
            m_empty = (m_level == 0);
        end
    endtask

    task automatic step(input logic rst, input logic pop);
        rrst      = rst;
        rpop      = pop;
        wptr_gray = gray4(wtot % 16);
        @(posedge rclk);
        model_edge(rst, pop);
        #1;
    endtask

    task automatic check_model(input string pfx);
        check({pfx, "_rempty"},   32'(rempty),   32'(m_empty));
        check({pfx, "_raempty"},  32'(raempty),  LEVEL_EN ? 32'(m_level <= 1) : 32'(m_empty));
        check({pfx, "_raddr"},    32'(raddr),    32'(m_reads % 8));
        check({pfx, "_rptr"},     32'(rptr),     32'(gray4(m_reads % 16)));
        check({pfx, "_rlevel"},   32'(rlevel),   LEVEL_EN ? 32'(m_level) : 32'd0);
        check({pfx, "_rpop_err"}, 32'(rpop_err), 32'(m_err));
    endtask

    typedef struct {
        logic       rst;
        logic       pop;
        int         w;
        logic       e_empty;
        logic       e_ae;
        logic [2:0] e_raddr;
        logic [3:0] e_rptr;
        int         e_level;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic pop, input int w,
                                input logic e_empty, input logic e_ae, input logic [2:0] e_raddr,
                                input logic [3:0] e_rptr, input int e_level, input logic e_err);
        vec_t v;
        v.rst = rst; v.pop = pop; v.w = w;
        v.e_empty = e_empty; v.e_ae = e_ae; v.e_raddr = e_raddr;
        v.e_rptr = e_rptr; v.e_level = e_level; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        logic [3:0] prev_rptr;
        logic [2:0] prev_raddr;
        bit seen_7_8, seen_15_0, seen_addr_wrap;
        int cyc;
        logic rst_r, pop_r;

        hist.push_back(0);
        hist.push_back(0);

        //            rst  pop  w  empty ae  raddr rptr     lvl err
        vecs.push_back(mk(1, 1, 2, 1, 1, 3'd0, 4'b0000, 0, 0)); // reset, pop and wptr ignored
        vecs.push_back(mk(1, 1, 2, 1, 1, 3'd0, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 3'd0, 4'b0000, 0, 0)); // one entry written
        vecs.push_back(mk(0, 0, 1, 1, 1, 3'd0, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 3'd0, 4'b0000, 1, 0)); // visible two edges later
        vecs.push_back(mk(0, 0, 3, 0, 1, 3'd0, 4'b0000, 1, 0)); // three entries written
        vecs.push_back(mk(0, 0, 3, 0, 1, 3'd0, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 0, 3, 0, 0, 3'd0, 4'b0000, 3, 0));
        vecs.push_back(mk(0, 1, 3, 0, 0, 3'd1, 4'b0001, 2, 0)); // drain
        vecs.push_back(mk(0, 1, 3, 0, 1, 3'd2, 4'b0011, 1, 0));
        vecs.push_back(mk(0, 1, 3, 1, 1, 3'd3, 4'b0010, 0, 0)); // empty on last pop edge
        vecs.push_back(mk(0, 1, 3, 1, 1, 3'd3, 4'b0010, 0, 1)); // underflow
        vecs.push_back(mk(0, 1, 3, 1, 1, 3'd3, 4'b0010, 0, 1));
        vecs.push_back(mk(0, 0, 3, 1, 1, 3'd3, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 0, 4, 1, 1, 3'd3, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 0, 5, 1, 1, 3'd3, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 0, 5, 0, 1, 3'd3, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, 5, 0, 1, 3'd4, 4'b0110, 1, 0)); // pop with write arriving
        vecs.push_back(mk(0, 1, 5, 1, 1, 3'd5, 4'b0111, 0, 0));
        vecs.push_back(mk(0, 0, 5, 1, 1, 3'd5, 4'b0111, 0, 0));
        vecs.push_back(mk(1, 1, 5, 1, 1, 3'd0, 4'b0000, 0, 0)); // mid-stream reset
        vecs.push_back(mk(0, 0, 0, 1, 1, 3'd0, 4'b0000, 0, 0));

        foreach (vecs[i]) begin
            string idx;
            idx = $sformatf("vec%0d", i);
            wtot = vecs[i].w;
            step(vecs[i].rst, vecs[i].pop);
            check({idx, "_rempty"},   32'(rempty),   32'(vecs[i].e_empty));
            check({idx, "_raempty"},  32'(raempty),  LEVEL_EN ? 32'(vecs[i].e_ae) : 32'(vecs[i].e_empty));
            check({idx, "_raddr"},    32'(raddr),    32'(vecs[i].e_raddr));
            check({idx, "_rptr"},     32'(rptr),     32'(vecs[i].e_rptr));
            check({idx, "_rlevel"},   32'(rlevel),   LEVEL_EN ? 32'(vecs[i].e_level) : 32'd0);
            check({idx, "_rpop_err"}, 32'(rpop_err), 32'(vecs[i].e_err));
        end

        // Wrap stream: 16 writes and 16 pops from a fresh reset.
        wtot = 0;
        step(1'b1, 1'b0);
        check_model("wrap_rst");
        prev_rptr  = rptr;
        prev_raddr = raddr;
        seen_7_8 = 0; seen_15_0 = 0; seen_addr_wrap = 0;
        cyc = 0;
        while (m_reads < 16 && cyc < 200) begin
            if (wtot < 16 && (wtot - m_reads) < 8) wtot++;
            step(1'b0, !m_empty);
            check_model("wrap");
            check("wrap_rptr_1bit", 32'($countones(rptr ^ prev_rptr) <= 1), 32'd1);
            if (prev_rptr == 4'b0100 && rptr == 4'b1100) seen_7_8 = 1;
            if (prev_rptr == 4'b1000 && rptr == 4'b0000) seen_15_0 = 1;
            if (prev_raddr == 3'd7 && raddr == 3'd0) seen_addr_wrap = 1;
            prev_rptr  = rptr;
            prev_raddr = raddr;
            cyc++;
        end
        check("wrap_timeout", 32'(m_reads >= 16), 32'd1);
        check("wrap_gray_0100_1100", 32'(seen_7_8), 32'd1);
        check("wrap_gray_1000_0000", 32'(seen_15_0), 32'd1);
        check("wrap_raddr_7_0", 32'(seen_addr_wrap), 32'd1);
        check("wrap_end_rempty", 32'(rempty), 32'd1);

        // Randomized traffic with occasional resets and underflow attempts.
        for (int n = 0; n < 800; n++) begin
            rst_r = ($urandom_range(0, 99) == 0);
            pop_r = 1'($urandom_range(0, 1));
            if (rst_r) wtot = 0;
            else if ($urandom_range(0, 2) != 0 && (wtot - m_reads) < 8) wtot++;
            step(rst_r, pop_r);
            check_model("rand");
            if (!rst_r) check("rand_rptr_1bit", 32'($countones(rptr ^ prev_rptr) <= 1), 32'd1);
            prev_rptr = rptr;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/afifo_rd_ctrl.md
# afifo_rd_ctrl

Read-domain controller for the crossbar's asynchronous FIFOs. It owns the read pointer, synchronises the write-domain Gray pointer into `rclk`, and produces registered empty, almost-empty and occupancy status. It sits beside the dual-port storage array, driving its read address. A write-side twin in the `wclk` domain mirrors it.

## Interface
- `ADDR_SIZE`, default 3: log2 of FIFO depth. Depth is `2**ADDR_SIZE`; pointers are `ADDR_SIZE+1` bits, the MSB being the wrap bit.
- `SYNC_STAGES`, default 2 (minimum 2): flop count in the write-pointer synchroniser.
- `AE_THRESH`, default 1 (range 0..`2**ADDR_SIZE`): almost-empty threshold, in entries.

Ports:
- `rclk`, input, 1 bit: read clock.
- `rrst`, input, 1 bit: reset, synchronous, active-high.
- `rpop`, input, 1 bit: pop request.
- `wptr_gray`, input, `ADDR_SIZE+1` bits: write pointer in Gray code, from the `wclk` domain, asynchronous.
- `rempty`, output, 1 bit: FIFO empty, registered.
- `raempty`, output, 1 bit: occupancy ≤ `AE_THRESH`, registered.
- `raddr`, output, `ADDR_SIZE` bits: binary read address to the storage array.
- `rptr`, output, `ADDR_SIZE+1` bits: Gray read pointer, registered, sent to the write domain.
- `rlevel`, output, `ADDR_SIZE+1` bits: occupancy as seen by the read side, range 0..`2**ADDR_SIZE`.
- `rpop_err`, output, 1 bit: one-cycle pulse when a pop is attempted while `rempty`=1.

## Operation
- Internal binary pointer `rbin[ADDR_SIZE:0]`.
- Pop acceptance: `pop_ok = rpop & ~rempty`.
- `rbin_next = rbin + pop_ok`. Arithmetic is modulo `2**(ADDR_SIZE+1)`, so it wraps naturally.
- `rgray_next = (rbin_next >> 1) ^ rbin_next`.
- Each edge: `rbin <= rbin_next` and `rptr <= rgray_next`.
- `raddr = rbin[ADDR_SIZE-1:0]`, driven straight from the register.
- Synchroniser: a `SYNC_STAGES`-deep shift chain on `wptr_gray`. Every stage resets to 0. The last stage is `wq_gray`.
- Empty: `rempty <= (rgray_next == wq_gray)`. This uses the next pointer, so a pop that drains the last entry asserts `rempty` on the same edge.
- Occupancy:
  - `wq_bin` is the Gray-to-binary conversion of `wq_gray`, computed as an XOR prefix from the MSB down.
  - `rlevel <= wq_bin - rbin_next`, evaluated in `ADDR_SIZE+1` bits.
  - `raempty <= (wq_bin - rbin_next) <= AE_THRESH`.
- `rpop_err <= rpop & rempty`. A rejected pop changes no pointer.
- No full detection is done here. Overflow protection belongs to the write side.

## Timing
- Reset values, all applied on the first `rclk` edge with `rrst`=1:
  - `rempty`=1, `raempty`=1, `rpop_err`=0.
  - `raddr`=0, `rptr`=0, `rlevel`=0.
  - All synchroniser stages = 0.
- Reset dominates `rpop`. A reset arriving mid-stream discards pointer state in one cycle, with no partial update.
- Pop latency: data at `raddr` is valid while `rempty`=0. A pop accepted at edge k advances `raddr` and `rptr` at edge k.
- Write visibility: a `wptr_gray` change that is stable before edge j appears in `wq_gray` after edge `j+SYNC_STAGES-1`. It is reflected in `rempty`, `raempty` and `rlevel` after edge `j+SYNC_STAGES`. With the defaults that is 2 edges after sampling.
- Empty is pessimistic: it may stay high after a write, but it never deasserts falsely.
- Simultaneous pop and pointer update: `rlevel` reflects both. For example, level 1 plus one pop plus one new write gives level 1 and `rempty`=0.
- Wrap-around: the pointer moves from binary 7 to 8 at `ADDR_SIZE`=3, so `raddr` returns to 0 and `rptr` goes 0100→1100. Full-range wrap 15→0 gives Gray 1000→0000.
- `rptr` changes at most one bit per edge.

## Configuration
- Macro: `AFIFO_RD_LEVEL_EN`.
- Defined: `rlevel` and `raempty` behave as specified above, including the Gray-to-binary converter and subtractor.
- Undefined: the converter and subtractor are not built. `rlevel` is tied to 0 and `raempty` equals `rempty`, cycle for cycle.
- Pointer, empty and `rpop_err` behaviour is identical in both builds, as is the port list.

## Test plan
All cases use `ADDR_SIZE`=3 and `SYNC_STAGES`=2.

- Reset: hold `rrst` for 2 edges with `rpop`=1 and `wptr_gray`=4'b0011. Required: `rempty`=1, `raempty`=1, `raddr`=0, `rptr`=0, `rlevel`=0, and `rpop_err`=0 during reset.
- Write visibility: after reset, drive `wptr_gray`=4'b0001 (one entry). Required: `rempty` falls 2 edges later, `rlevel`=1, `raempty`=1 (threshold 1).
- Drain: with 3 entries visible (`wptr_gray`=4'b0010), pop 3 times back to back. Required: `raddr` goes 1,2,3, `rlevel` goes 2,1,0, and `rempty`=1 on the edge of the third pop.
- Underflow: with `rempty`=1, set `rpop`=1 for 2 edges. Required: `rpop_err`=1 on both edges, and `raddr` and `rptr` unchanged.
- Wrap: stream 16 writes and 16 pops. Required: `raddr` wraps 7→0, `rptr` follows the Gray sequence including 0100→1100 and 1000→0000, `rptr` never changes more than one bit per edge, and `rempty` ends at 1.
- Macro off: repeat the drain case without `AFIFO_RD_LEVEL_EN`. Required: `rlevel`=0 throughout and `raempty`==`rempty` on every cycle.
